cpu_instr_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 37 +++
 rtl/cpu_instr_sequencer_if.sv | 36 +++
 rtl/prog_mem_16x12.sv | 27 ++
 rtl/cpu_instr_sequencer.sv | 112 +++++++++++
 tb/tb_cpu_instr_sequencer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU and its program sequencer:
// opcodes, instruction word layout, sequencer states and the NOP word.
package cpu_pkg;

  // NOT and SHL share 4'h8; NOP (to the CPU) and HALT (to the sequencer) share 4'hF.
  typedef enum logic [3:0] {
    OP_ADD      = 4'h0,
    OP_SUB      = 4'h1,
    OP_STORE    = 4'h2,
    OP_LOAD     = 4'h3,
    OP_AND      = 4'h5,
    OP_OR       = 4'h6,
    OP_XOR      = 4'h7,
    OP_NOT_SHL  = 4'h8,
    OP_SHR      = 4'h9,
    OP_NOP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_DONE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] addr;
    logic [3:0] data;
  } instr_t;

  localparam instr_t NOP_WORD = '{opcode: 4'hF, addr: 4'h0, data: 4'h0};

  function automatic logic [7:0] nib_to_bus(input logic [3:0] nib);
    return {nib, 4'b0000};
  endfunction

endpackage

// File: rtl/cpu_instr_sequencer_if.sv
// Bus between the program loader / controller and the instruction sequencer,
// including the CPU-facing instruction outputs.
interface cpu_instr_sequencer_if;
  import cpu_pkg::*;

  // No valid/ready pairs here: load_en and start are single-cycle qualifiers
  // that the sequencer samples on a rising edge and acts on only in IDLE;
  // halt_req is a level sampled each edge and acts only in ISSUE.
  logic        load_en;
  logic [3:0]  load_addr;
  logic [11:0] load_instr;
  logic        start;
  logic        halt_req;

  logic [7:0]  out_opcode_eightBit;
  logic [7:0]  out_addr_eightBit;
  logic [7:0]  out_data_eightBit;
  logic        out_ena;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  seq_state_e  dbg_state;

  modport master (
    output load_en, load_addr, load_instr, start, halt_req,
    input  out_opcode_eightBit, out_addr_eightBit, out_data_eightBit,
    input  out_ena, busy, done, pc, dbg_state
  );

  modport slave (
    input  load_en, load_addr, load_instr, start, halt_req,
    output out_opcode_eightBit, out_addr_eightBit, out_data_eightBit,
    output out_ena, busy, done, pc, dbg_state
  );

endinterface

// File: rtl/prog_mem_16x12.sv
// 16-entry program store: synchronous write, combinational read,
// asynchronous reset clears every entry to the NOP word.
module prog_mem_16x12
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [3:0] i_waddr,
  input  instr_t     i_wdata,
  input  logic [3:0] i_raddr,
  output instr_t     o_rdata
);

  instr_t r_mem [16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= NOP_WORD;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cpu_instr_sequencer.sv
// Program sequencer feeding the accumulator CPU: holds each stored instruction
// on registered buses for ISSUE_GAP cycles, stopping at HALT, entry 15 or halt_req.
module cpu_instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int ISSUE_GAP  = 2
)(
  input  logic                  clk,
  input  logic                  rst,
  cpu_instr_sequencer_if.slave  bus
);

  localparam logic [3:0] LAST_PC  = 4'(PROG_DEPTH - 1);
  localparam logic [3:0] LAST_CNT = 4'(ISSUE_GAP - 1);

  seq_state_e r_state, w_state_nxt;
  logic [3:0] r_pc, w_pc_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  instr_t     r_out, w_out_nxt;

  logic       w_mem_we;
  logic [3:0] w_raddr;
  instr_t     w_rdata;

  // A single read port suffices: IDLE only ever looks at entry 0,
  // ISSUE only ever looks ahead at the next entry.
  assign w_mem_we = (r_state == SEQ_IDLE) && bus.load_en;
  assign w_raddr  = (r_state == SEQ_ISSUE) ? (r_pc + 4'd1) : 4'd0;

  prog_mem_16x12 u_prog_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_mem_we),
    .i_waddr (bus.load_addr),
    .i_wdata (bus.load_instr),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
      r_pc    <= 4'd0;
      r_cnt   <= 4'd0;
      r_out   <= NOP_WORD;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    unique case (r_state)
      SEQ_IDLE: begin
        w_out_nxt = NOP_WORD;
        if (bus.start && !bus.load_en) begin
          w_pc_nxt  = 4'd0;
          w_cnt_nxt = 4'd0;
          if (w_rdata.opcode == OP_NOP_HALT) begin
            w_state_nxt = SEQ_DONE;
          end else begin
            w_state_nxt = SEQ_ISSUE;
            w_out_nxt   = w_rdata;
          end
        end
      end
      SEQ_ISSUE: begin
        if (bus.halt_req) begin
          w_state_nxt = SEQ_DONE;
          w_out_nxt   = NOP_WORD;
        end else if (r_cnt != LAST_CNT) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end else if ((r_pc == LAST_PC) || (w_rdata.opcode == OP_NOP_HALT)) begin
          // The HALT word is never placed on the buses.
          w_state_nxt = SEQ_DONE;
          w_out_nxt   = NOP_WORD;
        end else begin
          w_pc_nxt  = r_pc + 4'd1;
          w_cnt_nxt = 4'd0;
          w_out_nxt = w_rdata;
        end
      end
      SEQ_DONE: begin
        w_state_nxt = SEQ_IDLE;
        w_pc_nxt    = 4'd0;
        w_cnt_nxt   = 4'd0;
        w_out_nxt   = NOP_WORD;
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
        w_out_nxt   = NOP_WORD;
      end
    endcase
  end

  assign bus.out_opcode_eightBit = nib_to_bus(r_out.opcode);
  assign bus.out_addr_eightBit   = nib_to_bus(r_out.addr);
  assign bus.out_data_eightBit   = nib_to_bus(r_out.data);
  assign bus.out_ena             = (r_out.opcode == OP_STORE) && (r_state == SEQ_ISSUE);
  assign bus.busy                = (r_state == SEQ_ISSUE);
  assign bus.done                = (r_state == SEQ_DONE);
  assign bus.pc                  = r_pc;
  assign bus.dbg_state           = r_state;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Directed bench: two sequencers (hold 2 and hold 3) share one stimulus stream
// and are checked cycle by cycle against hand-derived bus values.
module tb_cpu_instr_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        rst;
  logic        t_load_en;
  logic [3:0]  t_load_addr;
  logic [11:0] t_load_instr;
  logic        t_start;
  logic        t_halt_req;

  int n_assert;
  int n_fail;

  logic [7:0] exp_q [$];

  logic [7:0] e_addr2 [10] = '{8'h40, 8'h40, 8'h00, 8'h00, 8'h70, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] e_data2 [10] = '{8'h00, 8'h00, 8'h50, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] e_ena2  [10] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0};
  logic [7:0] e_op3   [10] = '{8'h30, 8'h30, 8'h30, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20, 8'h20, 8'hF0};
  logic [7:0] e_ena3  [10] = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1, 8'h1, 8'h1, 8'h0};

  cpu_instr_sequencer_if if2 ();
  cpu_instr_sequencer_if if3 ();

  assign if2.load_en    = t_load_en;
  assign if2.load_addr  = t_load_addr;
  assign if2.load_instr = t_load_instr;
  assign if2.start      = t_start;
  assign if2.halt_req   = t_halt_req;
  assign if3.load_en    = t_load_en;
  assign if3.load_addr  = t_load_addr;
  assign if3.load_instr = t_load_instr;
  assign if3.start      = t_start;
  assign if3.halt_req   = t_halt_req;

  cpu_instr_sequencer #(.PROG_DEPTH(16), .ISSUE_GAP(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  cpu_instr_sequencer #(.PROG_DEPTH(16), .ISSUE_GAP(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [3:0] a, input logic [11:0] w);
    t_load_en    = 1'b1;
    t_load_addr  = a;
    t_load_instr = w;
    tick();
    t_load_en    = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_op2"},    if2.out_opcode_eightBit, 8'hF0);
    chk({tag, "_addr2"},  if2.out_addr_eightBit,   8'h00);
    chk({tag, "_data2"},  if2.out_data_eightBit,   8'h00);
    chk({tag, "_ena2"},   8'(if2.out_ena),         8'h0);
    chk({tag, "_busy2"},  8'(if2.busy),            8'h0);
    chk({tag, "_done2"},  8'(if2.done),            8'h0);
    chk({tag, "_pc2"},    8'(if2.pc),              8'h0);
    chk({tag, "_state2"}, 8'(if2.dbg_state),       8'(SEQ_IDLE));
    chk({tag, "_op3"},    if3.out_opcode_eightBit, 8'hF0);
    chk({tag, "_busy3"},  8'(if3.busy),            8'h0);
  endtask

  initial begin
    logic [7:0] e;
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    t_load_en    = 1'b0;
    t_load_addr  = 4'd0;
    t_load_instr = 12'h000;
    t_start      = 1'b0;
    t_halt_req   = 1'b0;

    // Reset values, then start on an empty program.
    tick();
    tick();
    chk_reset_values("rst");
    rst = 1'b0;
    tick();
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    chk("empty_done2", 8'(if2.done), 8'h1);
    chk("empty_busy2", 8'(if2.busy), 8'h0);
    chk("empty_op2",   if2.out_opcode_eightBit, 8'hF0);
    chk("empty_done3", 8'(if3.done), 8'h1);
    tick();
    chk("empty_done2_off", 8'(if2.done), 8'h0);
    chk("empty_idle2",     8'(if2.dbg_state), 8'(SEQ_IDLE));

    // LOAD / ADD / STORE / HALT program.
    load_word(4'd0, 12'h340);
    load_word(4'd1, 12'h005);
    load_word(4'd2, 12'h270);
    load_word(4'd3, 12'hF00);
    exp_q = {8'h30, 8'h30, 8'h00, 8'h00, 8'h20, 8'h20, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      e = exp_q.pop_front();
      chk($sformatf("prog_op2[%0d]", c),   if2.out_opcode_eightBit, e);
      chk($sformatf("prog_addr2[%0d]", c), if2.out_addr_eightBit,   e_addr2[c]);
      chk($sformatf("prog_data2[%0d]", c), if2.out_data_eightBit,   e_data2[c]);
      chk($sformatf("prog_ena2[%0d]", c),  8'(if2.out_ena),         e_ena2[c]);
      chk($sformatf("prog_busy2[%0d]", c), 8'(if2.busy),            8'(c < 6));
      chk($sformatf("prog_done2[%0d]", c), 8'(if2.done),            8'(c == 6));
      chk($sformatf("prog_op3[%0d]", c),   if3.out_opcode_eightBit, e_op3[c]);
      chk($sformatf("prog_ena3[%0d]", c),  8'(if3.out_ena),         e_ena3[c]);
      chk($sformatf("prog_done3[%0d]", c), 8'(if3.done),            8'(c == 9));
      if (c >= 6 && c <= 8)
        chk($sformatf("prog_addr3[%0d]", c), if3.out_addr_eightBit, 8'h70);
      tick();
    end
    tick();

    // Sixteen ADDs with no HALT: entry 15 ends the run, no wrap.
    for (int i = 0; i < 16; i++) load_word(4'(i), {4'h0, 4'(i), 4'h0});
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c < 32) begin
        chk($sformatf("full_pc2[%0d]", c),   8'(if2.pc), 8'(c / 2));
        chk($sformatf("full_addr2[%0d]", c), if2.out_addr_eightBit, 8'((c / 2) << 4));
        chk($sformatf("full_op2[%0d]", c),   if2.out_opcode_eightBit, 8'h00);
      end
      chk($sformatf("full_busy2[%0d]", c), 8'(if2.busy), 8'(c < 32));
      chk($sformatf("full_done2[%0d]", c), 8'(if2.done), 8'(c == 32));
      chk($sformatf("full_done3[%0d]", c), 8'(if3.done), 8'(c == 48));
      if (c < 48)
        chk($sformatf("full_pc3[%0d]", c), 8'(if3.pc), 8'(c / 3));
      tick();
    end
    chk("full_idle_pc2", 8'(if2.pc), 8'h0);

    // halt_req during the second cycle of instruction 2.
    load_word(4'd0, 12'h310);
    load_word(4'd1, 12'h320);
    load_word(4'd2, 12'h330);
    load_word(4'd3, 12'h340);
    load_word(4'd4, 12'hF00);
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("halt_addr2[%0d]", c), if2.out_addr_eightBit, 8'(((c / 2) + 1) << 4));
      chk($sformatf("halt_op2[%0d]", c),   if2.out_opcode_eightBit, 8'h30);
      if (c == 5) t_halt_req = 1'b1;
      tick();
    end
    t_halt_req = 1'b0;
    chk("halt_done2", 8'(if2.done), 8'h1);
    chk("halt_busy2", 8'(if2.busy), 8'h0);
    chk("halt_op2",   if2.out_opcode_eightBit, 8'hF0);
    chk("halt_addr2", if2.out_addr_eightBit,   8'h00);
    chk("halt_done3", 8'(if3.done), 8'h1);
    tick();
    chk("halt_idle2", 8'(if2.dbg_state), 8'(SEQ_IDLE));
    chk("halt_idle3", 8'(if3.dbg_state), 8'(SEQ_IDLE));
    tick();

    // load_en during ISSUE is ignored; the clean rerun must look identical.
    for (int run = 0; run < 2; run++) begin
      t_start = 1'b1;
      tick();
      t_start = 1'b0;
      for (int c = 0; c < 14; c++) begin
        if (c < 8) begin
          chk($sformatf("ign%0d_op2[%0d]", run, c),   if2.out_opcode_eightBit, 8'h30);
          chk($sformatf("ign%0d_addr2[%0d]", run, c), if2.out_addr_eightBit, 8'(((c / 2) + 1) << 4));
        end
        if (c < 12)
          chk($sformatf("ign%0d_addr3[%0d]", run, c), if3.out_addr_eightBit, 8'(((c / 3) + 1) << 4));
        chk($sformatf("ign%0d_ena2[%0d]", run, c),  8'(if2.out_ena), 8'h0);
        chk($sformatf("ign%0d_done2[%0d]", run, c), 8'(if2.done), 8'(c == 8));
        chk($sformatf("ign%0d_done3[%0d]", run, c), 8'(if3.done), 8'(c == 12));
        t_load_en    = (run == 0) && (c < 4);
        t_load_addr  = (c < 2) ? 4'd1 : 4'd4;
        t_load_instr = 12'h2FF;
        tick();
      end
      t_load_en = 1'b0;
      tick();
    end

    // start together with load_en in IDLE: the load wins, no run.
    t_load_en    = 1'b1;
    t_start      = 1'b1;
    t_load_addr  = 4'd0;
    t_load_instr = 12'hF00;
    tick();
    t_load_en = 1'b0;
    t_start   = 1'b0;
    chk("ldst_busy2",  8'(if2.busy), 8'h0);
    chk("ldst_done2",  8'(if2.done), 8'h0);
    chk("ldst_state2", 8'(if2.dbg_state), 8'(SEQ_IDLE));
    chk("ldst_busy3",  8'(if3.busy), 8'h0);
    tick();
    chk("ldst_done2_later", 8'(if2.done), 8'h0);
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    chk("ldst_halt0_done2", 8'(if2.done), 8'h1);
    chk("ldst_halt0_busy2", 8'(if2.busy), 8'h0);
    chk("ldst_halt0_done3", 8'(if3.done), 8'h1);
    tick();
    tick();

    // Asynchronous reset in the middle of a STORE.
    load_word(4'd0, 12'h270);
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    chk("mid_ena2_pre",  8'(if2.out_ena), 8'h1);
    chk("mid_addr2_pre", if2.out_addr_eightBit, 8'h70);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("midrst");
    rst     = 1'b0;
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    chk("midrst_cleared_done2", 8'(if2.done), 8'h1);
    chk("midrst_cleared_busy2", 8'(if2.busy), 8'h0);
    chk("midrst_cleared_done3", 8'(if3.done), 8'h1);
    tick();
    chk("midrst_idle2", 8'(if2.dbg_state), 8'(SEQ_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
